store_sequencer: RTL
====================

Name: store_sequencer

Overview:
- Sits between the MEM-stage store path and the data RAM write port.
- Accepts one store request per handshake (SB/SH/SW) and issues the byte-lane-aligned RAM write(s) with 4-bit byte enables.
- Splits misaligned SH/SW into two consecutive word writes. Stalls the pipeline while a store is outstanding and honours RAM back-pressure.

Parameters:
- SPLIT_EN, 1, 1 = misaligned stores are split into two writes; 0 = misaligned stores are rejected with err (no write).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  sequencer can accept a request
- req_addr  in  32  byte address (ALUResult)
- req_data  in  32  rs2 store data
- req_funct3  in  3  000 SB, 001 SH, 010 SW; others illegal
- mem_valid  out  1  RAM write command valid
- mem_ready  in  1  RAM accepts the command this cycle
- mem_addr  out  32  word-aligned RAM address, bits [1:0] always 00
- mem_we4  out  4  byte write enables
- mem_wdata  out  32  lane-shifted write data; disabled lanes are 0
- stall  out  1  pipeline stall, high while state != IDLE
- err  out  1  one-cycle pulse on illegal funct3 or rejected misaligned store

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. While rst_n=0 at a rising edge:
  - state goes to IDLE;
  - mem_valid=0, mem_we4=0, mem_addr=0, mem_wdata=0, err=0, stall=0;
  - req_ready is 1 after reset.
- States:
  - IDLE: req_ready=1, mem_valid=0.
  - FIRST: first (or only) write.
  - SECOND: upper-word write of a split store.
  - req_ready=0 in FIRST and SECOND.
- Accept: req_valid && req_ready at edge N. The request is registered, including off=req_addr[1:0]. The first write is presented from cycle N+1, giving a minimum latency of 1 cycle.
- Mask and data generation:
  - base = SB 0001, SH 0011, SW 1111.
  - m8 = 8-bit base << off.
  - d64 = {32'b0, data} << (8*off); funct3 masks data to 8/16/32 bits before shifting.
  - split = (m8[7:4] != 0).
- FIRST:
  - mem_valid=1, mem_addr={addr[31:2],2'b00}, mem_we4=m8[3:0], mem_wdata=d64[31:0].
  - Outputs hold stable until mem_ready=1.
  - On mem_ready: go to SECOND if split, else IDLE.
- SECOND:
  - mem_valid=1, mem_addr={addr[31:2],2'b00}+4 (wraps modulo 2^32; 0xFFFFFFFC+4 = 0), mem_we4=m8[7:4], mem_wdata=d64[63:32].
  - Outputs hold until mem_ready; then go to IDLE.
- mem_valid=0 implies mem_we4=0, mem_addr=0, mem_wdata=0.
- Illegal funct3 (011–111):
  - request is consumed, state stays IDLE, no write;
  - err=1 for the cycle after accept.
- SPLIT_EN=0 and split=1: request is consumed, no write, err pulse, state stays IDLE.
- Aligned SB/SH/SW never split: SB never splits; SH splits only at off=11; SW splits at any off != 00.
- Back-to-back: the next request can be accepted in the IDLE cycle following completion, giving a best throughput of 1 store per 2 cycles.
- Request inputs are ignored while req_ready=0. The upstream holds req_* stable while req_valid && !req_ready.
- Reset mid-operation (FIRST or SECOND): the pending write is dropped, including the second half of a split; all outputs return to reset values the next cycle.
- Simultaneous mem_ready and state exit: the transition happens on that edge. No extra idle cycle occurs between FIRST and SECOND.

Test Plan:
- SB addr=0x1003, data=0xAABBCCDD, mem_ready=1 → one write: addr 0x1000, we4 1000, wdata 0xDD000000; stall high for 1 cycle.
- SH addr=0x2002, data=0x1234 → one write: addr 0x2000, we4 1100, wdata 0x12340000.
- SW addr=0x3001, data=0x11223344 → write 1: addr 0x3000, we4 1110, wdata 0x22334400; write 2: addr 0x3004, we4 0001, wdata 0x00000011.
- SH addr=0xFFFFFFFF, data=0xBEEF → write 1: addr 0xFFFFFFFC, we4 1000, wdata 0xEF000000; write 2: addr 0x00000000, we4 0001, wdata 0x000000BE.
- Back-pressure: split SW with mem_ready low for 3 cycles in FIRST → outputs stable all 3 cycles; SECOND entered only after mem_ready; rst_n=0 asserted in SECOND → mem_valid=0 and state IDLE next cycle, with no second write.
- funct3=011 → no mem_valid, err pulses once, req_ready stays 1. SPLIT_EN=0 with SW addr=0x2 → no write, err pulses once.

Source files
------------

// File: rtl/store_sequencer.sv
// Store sequencer: turns one SB/SH/SW request into byte-lane aligned RAM
// writes, splitting word-crossing stores into two consecutive writes.
module store_sequencer #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [2:0]  req_funct3,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we4,
    output logic [31:0] mem_wdata,
    output logic        stall,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        SECOND
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] wa_q, wa_d;
    logic [7:0]  m8_q, m8_d;
    logic [63:0] d64_q, d64_d;
    logic        err_q, err_d;

    logic [3:0]  base;
    logic [31:0] dmask;
    logic        legal;
    logic [7:0]  m8_new;
    logic [63:0] d64_new;
    logic        split_new;

    // Lane mask and shifted data for the incoming request
    always_comb begin
        base  = 4'b0000;
        dmask = 32'h0;
        legal = 1'b1;
        unique case (req_funct3)
            3'b000: begin
                base  = 4'b0001;
                dmask = {24'h0, req_data[7:0]};
            end
            3'b001: begin
                base  = 4'b0011;
                dmask = {16'h0, req_data[15:0]};
            end
            3'b010: begin
                base  = 4'b1111;
                dmask = req_data;
            end
            default: legal = 1'b0;
        endcase
        m8_new    = {4'b0000, base} << req_addr[1:0];
        d64_new   = {32'h0, dmask} << {req_addr[1:0], 3'b000};
        split_new = |m8_new[7:4];
    end

    always_comb begin
        state_d = state_q;
        wa_d    = wa_q;
        m8_d    = m8_q;
        d64_d   = d64_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!legal || (split_new && !SPLIT_EN)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = FIRST;
                        wa_d    = req_addr[31:2];
                        m8_d    = m8_new;
                        d64_d   = d64_new;
                    end
                end
            end
            FIRST: begin
                if (mem_ready) begin
                    state_d = (|m8_q[7:4]) ? SECOND : IDLE;
                end
            end
            SECOND: begin
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        stall     = (state_q != IDLE);
        err       = err_q;
        mem_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_we4   = 4'b0000;
        mem_wdata = 32'h0;
        unique case (state_q)
            FIRST: begin
                mem_valid = 1'b1;
                mem_addr  = {wa_q, 2'b00};
                mem_we4   = m8_q[3:0];
                mem_wdata = d64_q[31:0];
            end
            SECOND: begin
                // Word index wraps naturally at the top of the address space
                mem_valid = 1'b1;
                mem_addr  = {wa_q + 30'd1, 2'b00};
                mem_we4   = m8_q[7:4];
                mem_wdata = d64_q[63:32];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wa_q    <= 30'h0;
            m8_q    <= 8'h0;
            d64_q   <= 64'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wa_q    <= wa_d;
            m8_q    <= m8_d;
            d64_q   <= d64_d;
            err_q   <= err_d;
        end
    end

endmodule
